// File: rtl/usb_tx_if.sv
// Byte handshake between the TX packet controller (master) and the USB TX encoder (slave).
interface usb_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_err;

    modport master (
        output tx_start, tx_data, tx_last, tx_valid,
        input  tx_ready, tx_busy, tx_err
    );

    modport slave (
        input  tx_start, tx_data, tx_last, tx_valid,
        output tx_ready, tx_busy, tx_err
    );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit path: bit timer, serializer, bit stuffer and NRZI line encoder.
// Sends SYNC, the caller's bytes LSB-first, then SE0/SE0/J end-of-packet.
module usb_tx_encoder #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter logic [7:0]  SYNC_BYTE    = 8'h80
) (
    input  logic    clk,
    input  logic    rst,
    usb_tx_if.slave tx,
    output logic    dplus,
    output logic    dminus
);
    localparam int unsigned         TimerW   = $clog2(CLKS_PER_BIT);
    localparam logic [TimerW-1:0]   TimerMax = TimerW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StSync, StData, StEopSe0, StEopJ} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              cur_last_q, cur_last_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic              buf_last_q, buf_last_d;
    logic              buf_full_q, buf_full_d;
    logic [2:0]        ones_cnt_q, ones_cnt_d;
    logic              dplus_q, dplus_d;
    logic              dminus_q, dminus_d;
    logic              err_q, err_d;

    logic       ready;
    logic       accept;
    logic       bit_wrap;
    logic       send_en;
    logic       send_bit;
    logic [2:0] next_idx;

    assign ready    = ~buf_full_q & ((state_q == StSync) | (state_q == StData));
    assign accept   = tx.tx_valid & ready;
    assign bit_wrap = (timer_q == TimerMax);
    assign next_idx = bit_idx_q + 3'd1;

    assign tx.tx_ready = ready;
    assign tx.tx_busy  = (state_q != StIdle);
    assign tx.tx_err   = err_q;
    assign dplus       = dplus_q;
    assign dminus      = dminus_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = (state_q == StIdle || bit_wrap) ? '0 : timer_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        cur_last_d = cur_last_q;
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        buf_full_d = buf_full_q;
        ones_cnt_d = ones_cnt_q;
        dplus_d    = dplus_q;
        dminus_d   = dminus_q;
        err_d      = 1'b0;
        send_en    = 1'b0;
        send_bit   = 1'b0;

        if (accept) begin
            buf_data_d = tx.tx_data;
            buf_last_d = tx.tx_last;
            buf_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                dplus_d  = 1'b1;
                dminus_d = 1'b0;
                if (tx.tx_start) begin
                    state_d    = StSync;
                    shift_d    = SYNC_BYTE;
                    bit_idx_d  = 3'd0;
                    cur_last_d = 1'b0;
                    send_en    = 1'b1;
                    send_bit   = SYNC_BYTE[0];
                end
            end
            StSync, StData: begin
                if (bit_wrap) begin
                    if (ones_cnt_q == 3'd6) begin
                        // Stuffed zero: bit index holds so the data bit is not lost.
                        send_en  = 1'b1;
                        send_bit = 1'b0;
                    end else if (bit_idx_q != 3'd7) begin
                        bit_idx_d = next_idx;
                        send_en   = 1'b1;
                        send_bit  = shift_q[next_idx];
                    end else if (cur_last_q) begin
                        state_d    = StEopSe0;
                        bit_idx_d  = 3'd0;
                        ones_cnt_d = 3'd0;
                        dplus_d    = 1'b0;
                        dminus_d   = 1'b0;
                    end else if (buf_full_q) begin
                        state_d    = StData;
                        shift_d    = buf_data_q;
                        cur_last_d = buf_last_q;
                        buf_full_d = 1'b0;
                        bit_idx_d  = 3'd0;
                        send_en    = 1'b1;
                        send_bit   = buf_data_q[0];
                    end else if (accept) begin
                        // Byte arriving on the boundary cycle bypasses the holding buffer.
                        state_d    = StData;
                        shift_d    = tx.tx_data;
                        cur_last_d = tx.tx_last;
                        buf_full_d = 1'b0;
                        bit_idx_d  = 3'd0;
                        send_en    = 1'b1;
                        send_bit   = tx.tx_data[0];
                    end else begin
                        state_d    = StEopSe0;
                        err_d      = 1'b1;
                        bit_idx_d  = 3'd0;
                        ones_cnt_d = 3'd0;
                        dplus_d    = 1'b0;
                        dminus_d   = 1'b0;
                    end
                end
            end
            StEopSe0: begin
                if (bit_wrap) begin
                    if (bit_idx_q == 3'd1) begin
                        state_d  = StEopJ;
                        dplus_d  = 1'b1;
                        dminus_d = 1'b0;
                    end else begin
                        bit_idx_d = next_idx;
                    end
                end
            end
            StEopJ: begin
                if (bit_wrap) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // NRZI: a zero toggles J<->K, a one holds the line.
        if (send_en) begin
            if (!send_bit) begin
                dplus_d  = ~dplus_q;
                dminus_d = ~dminus_q;
            end
            ones_cnt_d = send_bit ? ones_cnt_q + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            cur_last_q <= 1'b0;
            buf_data_q <= 8'h00;
            buf_last_q <= 1'b0;
            buf_full_q <= 1'b0;
            ones_cnt_q <= 3'd0;
            dplus_q    <= 1'b1;
            dminus_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            cur_last_q <= cur_last_d;
            buf_data_q <= buf_data_d;
            buf_last_q <= buf_last_d;
            buf_full_q <= buf_full_d;
            ones_cnt_q <= ones_cnt_d;
            dplus_q    <= dplus_d;
            dminus_q   <= dminus_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: expected line streams are hand-written J/K/0 strings.
module tb_usb_tx_encoder;
    localparam int Clks = 8;

    logic clk;
    logic rst;
    logic dplus;
    logic dminus;

    int n_tests;
    int n_fail;
    int busy_cnt;
    int err_seen;
    logic [8:0] feed_q[$];

    usb_tx_if ifc ();

    usb_tx_encoder #(
        .CLKS_PER_BIT(Clks),
        .SYNC_BYTE   (8'h80)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tx    (ifc),
        .dplus (dplus),
        .dminus(dminus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [1:0] line_of(input byte ch);
        case (ch)
            "J":     return 2'b10;
            "K":     return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic present();
        logic [8:0] e;
        if (feed_q.size() > 0) begin
            e            = feed_q.pop_front();
            ifc.tx_last  = e[8];
            ifc.tx_data  = e[7:0];
            ifc.tx_valid = 1'b1;
        end else begin
            ifc.tx_valid = 1'b0;
        end
    endtask

    // One clock: handshake bookkeeping, then sample 1 time unit after the edge.
    task automatic cycle();
        logic acc;
        acc = ifc.tx_valid && ifc.tx_ready;
        @(posedge clk);
        #1;
        if (acc) present();
        if (ifc.tx_err) err_seen++;
        if (ifc.tx_busy) busy_cnt++;
    endtask

    task automatic run_packet(input string tag, input string pat, input int exp_err,
                              input bit glitch);
        logic [1:0] want;
        logic [1:0] got;
        logic [1:0] bad_got;
        bit         bad;
        busy_cnt = 0;
        err_seen = 0;
        present();
        ifc.tx_start = 1'b1;
        cycle();
        ifc.tx_start = 1'b0;
        check({tag, "_ready0"}, ifc.tx_ready, 1);
        for (int p = 0; p < pat.len(); p++) begin
            want    = line_of(pat[p]);
            bad     = 1'b0;
            bad_got = want;
            for (int c = 0; c < Clks; c++) begin
                got = {dplus, dminus};
                if (got !== want && !bad) begin
                    bad     = 1'b1;
                    bad_got = got;
                end
                ifc.tx_start = glitch && (c == 3) && (p == 10 || p == 17);
                cycle();
            end
            check($sformatf("%s_bit%0d", tag, p), bad_got, want);
        end
        ifc.tx_start = 1'b0;
        check({tag, "_busy_clks"}, busy_cnt, pat.len() * Clks);
        check({tag, "_err_pulses"}, err_seen, exp_err);
        check({tag, "_idle_line"}, {dplus, dminus}, 2'b10);
        check({tag, "_idle_busy"}, ifc.tx_busy, 0);
        check({tag, "_drained"}, feed_q.size() + int'(ifc.tx_valid), 0);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst          = 1'b1;
        ifc.tx_start = 1'b0;
        ifc.tx_data  = 8'h00;
        ifc.tx_last  = 1'b0;
        ifc.tx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dplus", dplus, 1);
        check("rst_dminus", dminus, 0);
        check("rst_busy", ifc.tx_busy, 0);
        check("rst_ready", ifc.tx_ready, 0);
        check("rst_err", ifc.tx_err, 0);
        rst = 1'b0;
        repeat (3) cycle();
        check("idle_line", {dplus, dminus}, 2'b10);

        // Single zero byte: every data bit toggles the line.
        feed_q = '{9'h100};
        run_packet("b00", "KJKJKJKKJKJKJKJK00J", 0, 1'b0);

        // 0xFF: stuffed zero in the 14th bit period.
        feed_q = '{9'h1FF};
        run_packet("bFF", "KJKJKJKKKKKKKJJJJ00J", 0, 1'b0);

        // 0x7E then 0x3F: stuffing in both bytes, second one after bit 5.
        feed_q = '{9'h07E, 9'h13F};
        run_packet("b7E3F", "KJKJKJKKJJJJJJJKJJJJJJJKJK00J", 0, 1'b0);

        // 0xA5 not last, no follow-up byte: underflow abort.
        feed_q = '{9'h0A5};
        run_packet("bA5abort", "KJKJKJKKKJJKJJKK00J", 1, 1'b0);

        // tx_start pulses in DATA and SE0 must not disturb the packet.
        feed_q = '{9'h100};
        run_packet("b00glitch", "KJKJKJKKJKJKJKJK00J", 0, 1'b1);

        // Reset in the middle of the data byte.
        feed_q = '{9'h100};
        present();
        ifc.tx_start = 1'b1;
        cycle();
        ifc.tx_start = 1'b0;
        repeat (12 * Clks) cycle();
        check("mid_busy_before", ifc.tx_busy, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        ifc.tx_valid = 1'b0;
        check("midrst_line", {dplus, dminus}, 2'b10);
        check("midrst_busy", ifc.tx_busy, 0);
        check("midrst_ready", ifc.tx_ready, 0);
        check("midrst_err", ifc.tx_err, 0);
        repeat (Clks) cycle();
        check("midrst_hold_line", {dplus, dminus}, 2'b10);
        check("midrst_hold_busy", ifc.tx_busy, 0);

        // Clean packet after the abortive reset.
        feed_q = '{9'h1FF};
        run_packet("bFF_after_rst", "KJKJKJKKKKKKKJJJJ00J", 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
